align_shift_pipe: RTL and testbench
===================================

// Module: align_shift_pipe
// PURPOSE
//  Parametrised, pipelined successor to the fixed 16-lane combinational alignment shifter.
//  - Takes LANES signed products and their unsigned exponents.
//  - Finds the maximum exponent over the enabled lanes.
//  - Arithmetic-right-shifts each lane by (emax - exp) so every lane shares emax.
//  - Sits between the PE multiplier array and the adder tree; valid/ready on both sides.
// PARAMETERS
//  LANES  16  number of lanes (>=2)
//  WIDTH  49  signed data width per lane
//  EXP_W  10  unsigned exponent width per lane
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              synchronous reset, active-high
//  in_valid   in   1              input beat valid
//  in_ready   out  1              block can accept input beat
//  in_data    in   LANES*WIDTH    lane i at [i*WIDTH +: WIDTH], two's complement
//  in_exp     in   LANES*EXP_W    lane i at [i*EXP_W +: EXP_W], unsigned
//  in_mask    in   LANES          1 = lane enabled; 0 = lane forced to zero, excluded from max
//  out_valid  out  1              output beat valid
//  out_ready  in   1              downstream accepts output beat
//  out_data   out  LANES*WIDTH    aligned lanes, same packing as in_data
//  out_emax   out  EXP_W          common exponent of out_data
//  out_sticky out  LANES          per-lane OR of discarded bits (ALIGN_STICKY_EN only)
// BEHAVIOUR
//  - Stage S1 (registered): latches data and mask; computes emax = max(in_exp[i]) over mask[i]=1.
//  - Stage S2 (registered): per lane, sh = emax - exp[i] (EXP_W bits, never negative).
//    - Lane result = data[i] >>> sh.
//    - If sh >= WIDTH, lane result = {WIDTH{data[i][WIDTH-1]}}.
//    - Masked lanes output 0.
//  - Latency is exactly 2 cycles when out_ready=1 continuously.
//  - Throughput is 1 beat/cycle.
//  - Handshake:
//    - A beat transfers on in_valid & in_ready.
//    - A beat leaves on out_valid & out_ready.
//    - in_valid is not required to wait on in_ready.
//    - Data/exp/mask are sampled only on transfer.
//  - Advance rules:
//    - s2_adv = ~s2_valid | out_ready.
//    - s1_adv = ~s1_valid | s2_adv.
//    - in_ready = s1_adv (combinational from out_ready; no skid buffer).
//  - Stall: out_data, out_emax and out_sticky hold stable while out_valid & ~out_ready.
//  - Bubbles:
//    - A stage with valid=0 loads when its upstream presents a beat.
//    - Data registers of an invalid stage are don't-care.
//  - All-masked beat: emax=0; all lanes 0; sticky=0; still produces an output beat.
//  - Equal exponents: sh=0, data passes unchanged.
//  - Reset:
//    - out_valid=0, internal stage valids=0, out_data=0, out_emax=0, out_sticky=0.
//    - in_ready=1 in the first cycle after reset.
//    - Reset mid-operation drops all in-flight beats; none are emitted afterwards.
//  - Simultaneous accept/emit with a full pipe: both occur in the same cycle with no bubble.
// CONFIGURATION
//  ALIGN_STICKY_EN defined:
//    - out_sticky[i] = OR of data[i][min(sh,WIDTH)-1:0] (bits shifted out).
//    - Registered alongside out_data; 0 for masked lanes or sh=0.
//  ALIGN_STICKY_EN undefined:
//    - out_sticky port is absent.
//    - No sticky logic is built; all other behaviour is identical.
// TESTING
//  1. Reset held 3 cycles, then released with in_valid=0
//     -> out_valid=0, out_data=0, in_ready=1.
//  2. LANES=16, all mask=1, exp lane0=20, others=18, data=0x100 each, out_ready=1
//     -> after 2 cycles: emax=20, lane0=0x100, lanes1..15=0x40, sticky=0.
//  3. Lane3 data=-5 (all-ones pattern ...FB), exp=2, emax=60
//     -> sh=58>=49, lane3 = all ones (-1), sticky[3]=1.
//  4. Stream 8 back-to-back beats, out_ready=0 for cycles 3-5
//     -> in_ready drops once both stages are full, no beat lost or duplicated,
//        output order preserved, outputs stable while stalled.
//  5. in_mask=0 on all lanes, exp=all 0x3FF
//     -> emax=0, out_data=0, one output beat.
//  6. Assert rst with 2 beats in flight
//     -> neither beat appears on the output after reset deasserts.

Source files
------------

// File: rtl/align_shift_pipe.sv
// -----------------------------------------------------------------------------
// align_shift_pipe
//   Two-stage pipelined exponent alignment shifter. It sits between the PE
//   multiplier array and the adder tree.
//   Stage S1 captures the beat and finds the largest exponent over the enabled
//   lanes. Stage S2 arithmetic-right-shifts every enabled lane by
//   (emax - exp[i]), so all lanes share the exponent emax. Disabled lanes are
//   forced to zero.
//
//   Optional feature macro: ALIGN_STICKY_EN
//     defined   -> out_sticky port present. It carries the per-lane OR of the
//                  bits discarded by the shift.
//     undefined -> no out_sticky port and no sticky logic.
//
// Parameters
//   LANES  number of lanes (>= 2)
//   WIDTH  signed data width per lane
//   EXP_W  unsigned exponent width per lane (< 32)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   input beat valid
//   in_ready   block can accept an input beat (combinational from out_ready)
//   in_data    lane i at [i*WIDTH +: WIDTH], two's complement
//   in_exp     lane i at [i*EXP_W +: EXP_W], unsigned
//   in_mask    1 = lane enabled, 0 = lane zeroed and excluded from the max
//   out_valid  output beat valid
//   out_ready  downstream accepts the output beat
//   out_data   aligned lanes, same packing as in_data
//   out_emax   common exponent of out_data
//   out_sticky per-lane OR of discarded bits (ALIGN_STICKY_EN only)
// -----------------------------------------------------------------------------
module align_shift_pipe #(
  parameter int LANES = 16,
  parameter int WIDTH = 49,
  parameter int EXP_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES*EXP_W-1:0] in_exp,
  input  logic [LANES-1:0]       in_mask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [EXP_W-1:0]       out_emax
`ifdef ALIGN_STICKY_EN
  ,
  output logic [LANES-1:0]       out_sticky
`endif
);

  // Pipeline handshake: a stage may load when it is empty or when it is
  // being drained downstream in the same cycle.
  logic s2_adv;
  logic s1_adv;

  // Stage S1 state
  logic                   s1_valid_q, s1_valid_d;
  logic [LANES*WIDTH-1:0] s1_data_q,  s1_data_d;
  logic [LANES*EXP_W-1:0] s1_exp_q,   s1_exp_d;
  logic [LANES-1:0]       s1_mask_q,  s1_mask_d;
  logic [EXP_W-1:0]       s1_emax_q,  s1_emax_d;

  // Stage S2 state, which also drives the outputs directly
  logic                   s2_valid_q, s2_valid_d;
  logic [LANES*WIDTH-1:0] out_data_q, out_data_d;
  logic [EXP_W-1:0]       out_emax_q, out_emax_d;
`ifdef ALIGN_STICKY_EN
  logic [LANES-1:0]       out_sticky_q, out_sticky_d;
`endif

  // Combinational helpers
  logic [EXP_W-1:0]       in_emax;
  logic [EXP_W-1:0]       lane_sh  [LANES];
  logic [WIDTH-1:0]       lane_src [LANES];
  logic [LANES*WIDTH-1:0] align_data;
`ifdef ALIGN_STICKY_EN
  logic [WIDTH-1:0]       lane_lost [LANES];
  logic [LANES-1:0]       align_sticky;
`endif

  assign s2_adv    = ~s2_valid_q | out_ready;
  assign s1_adv    = ~s1_valid_q | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign out_emax  = out_emax_q;
`ifdef ALIGN_STICKY_EN
  assign out_sticky = out_sticky_q;
`endif

  // Maximum exponent over enabled lanes. An all-masked beat yields zero.
  always_comb begin
    in_emax = '0;
    for (int i = 0; i < LANES; i++) begin
      in_emax = (in_mask[i] && (in_exp[i*EXP_W +: EXP_W] > in_emax))
                ? in_exp[i*EXP_W +: EXP_W] : in_emax;
    end
  end

  // S1 next state: capture the beat only when it actually transfers.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_exp_d   = s1_exp_q;
    s1_mask_d  = s1_mask_q;
    s1_emax_d  = s1_emax_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_exp_d  = in_exp;
        s1_mask_d = in_mask;
        s1_emax_d = in_emax;
      end else begin
        s1_data_d = s1_data_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Per-lane alignment shift of the S1 beat. The shift amount cannot be
  // negative for an enabled lane because emax is the max over enabled lanes.
  always_comb begin
    align_data = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_src[i] = s1_data_q[i*WIDTH +: WIDTH];
      lane_sh[i]  = s1_emax_q - s1_exp_q[i*EXP_W +: EXP_W];
      if (!s1_mask_q[i]) begin
        align_data[i*WIDTH +: WIDTH] = '0;
      end else if (32'(lane_sh[i]) >= WIDTH) begin
        // Everything is shifted out: only the sign survives.
        align_data[i*WIDTH +: WIDTH] = {WIDTH{lane_src[i][WIDTH-1]}};
      end else begin
        align_data[i*WIDTH +: WIDTH] = $signed(lane_src[i]) >>> lane_sh[i];
      end
    end
  end

`ifdef ALIGN_STICKY_EN
  // Sticky: OR of the bits that fall off the bottom. A left-shifted all-ones
  // mask is zero once sh >= WIDTH, so its inverse then selects every bit.
  always_comb begin
    align_sticky = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_lost[i]    = lane_src[i] & ~({WIDTH{1'b1}} << lane_sh[i]);
      align_sticky[i] = s1_mask_q[i] & (|lane_lost[i]);
    end
  end
`endif

  // S2 next state: output registers only change when the stage advances,
  // which keeps them stable during a downstream stall.
  always_comb begin
    s2_valid_d = s2_valid_q;
    out_data_d = out_data_q;
    out_emax_d = out_emax_q;
`ifdef ALIGN_STICKY_EN
    out_sticky_d = out_sticky_q;
`endif
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = align_data;
        out_emax_d = s1_emax_q;
`ifdef ALIGN_STICKY_EN
        out_sticky_d = align_sticky;
`endif
      end else begin
        out_data_d = out_data_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline registers with synchronous reset. Reset drops any in-flight beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_exp_q   <= '0;
      s1_mask_q  <= '0;
      s1_emax_q  <= '0;
      s2_valid_q <= 1'b0;
      out_data_q <= '0;
      out_emax_q <= '0;
`ifdef ALIGN_STICKY_EN
      out_sticky_q <= '0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_exp_q   <= s1_exp_d;
      s1_mask_q  <= s1_mask_d;
      s1_emax_q  <= s1_emax_d;
      s2_valid_q <= s2_valid_d;
      out_data_q <= out_data_d;
      out_emax_q <= out_emax_d;
`ifdef ALIGN_STICKY_EN
      out_sticky_q <= out_sticky_d;
`endif
    end
  end

endmodule

// File: tb/tb_align_shift_pipe.sv
// -----------------------------------------------------------------------------
// tb_align_shift_pipe
//   Randomised plus directed bench for align_shift_pipe. Expected beats come
//   from an arithmetic reference model (floor division by 2^sh) held in a
//   queue and popped whenever an output beat transfers.
// -----------------------------------------------------------------------------
module tb_align_shift_pipe;

  localparam int LANES = 16;
  localparam int WIDTH = 49;
  localparam int EXP_W = 10;

  typedef struct {
    logic [LANES*WIDTH-1:0] data;
    logic [EXP_W-1:0]       emax;
    logic [LANES-1:0]       sticky;
  } beat_t;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic [LANES*EXP_W-1:0] in_exp;
  logic [LANES-1:0]       in_mask;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_data;
  logic [EXP_W-1:0]       out_emax;
`ifdef ALIGN_STICKY_EN
  logic [LANES-1:0]       out_sticky;
`endif

  int    n_cmp;
  int    n_bad;
  int    emits;
  beat_t exp_q[$];
  beat_t held;
  logic  stall_prev;

  align_shift_pipe #(.LANES(LANES), .WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_exp    (in_exp),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_emax  (out_emax)
`ifdef ALIGN_STICKY_EN
    ,
    .out_sticky(out_sticky)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: emax is the max over enabled lanes. Each lane is floor(d / 2^sh),
  // saturating to the sign once sh >= WIDTH. Sticky is a nonzero remainder.
  function automatic beat_t model(input logic [LANES*WIDTH-1:0] d,
                                  input logic [LANES*EXP_W-1:0] e,
                                  input logic [LANES-1:0] m);
    beat_t r;
    int    emax;
    emax     = 0;
    r.data   = '0;
    r.sticky = '0;
    for (int i = 0; i < LANES; i++)
      if (m[i] && int'(e[i*EXP_W +: EXP_W]) > emax) emax = int'(e[i*EXP_W +: EXP_W]);
    r.emax = EXP_W'(emax);
    for (int i = 0; i < LANES; i++) begin
      logic signed [WIDTH-1:0] ls;
      longint dv, q, rem, p;
      int sh;
      ls = d[i*WIDTH +: WIDTH];
      dv = ls;
      sh = emax - int'(e[i*EXP_W +: EXP_W]);
      if (!m[i]) begin
        q = 0;
        rem = 0;
      end else if (sh >= WIDTH) begin
        q = (dv < 0) ? -64'sd1 : 64'sd0;
        rem = dv;
      end else begin
        p = longint'(1) << sh;
        q = dv / p;
        rem = dv % p;
        if (rem != 0 && dv < 0) q = q - 1;
      end
      r.data[i*WIDTH +: WIDTH] = q[WIDTH-1:0];
      r.sticky[i] = (rem != 0);
    end
    return r;
  endfunction

  task automatic cmp_beat(input string tag, input beat_t b);
    for (int i = 0; i < LANES; i++)
      chk($sformatf("%s_lane%0d", tag, i), 64'(out_data[i*WIDTH +: WIDTH]),
          64'(b.data[i*WIDTH +: WIDTH]));
    chk($sformatf("%s_emax", tag), 64'(out_emax), 64'(b.emax));
`ifdef ALIGN_STICKY_EN
    chk($sformatf("%s_sticky", tag), 64'(out_sticky), 64'(b.sticky));
`endif
  endtask

  task automatic rand_beat(output logic [LANES*WIDTH-1:0] d,
                           output logic [LANES*EXP_W-1:0] e,
                           output logic [LANES-1:0] m);
    int base;
    logic [63:0] rv;
    base = $urandom_range(0, 900);
    for (int i = 0; i < LANES; i++) begin
      rv = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) rv = rv >> $urandom_range(20, 60);
      d[i*WIDTH +: WIDTH] = rv[WIDTH-1:0];
      e[i*EXP_W +: EXP_W] = EXP_W'(base + int'($urandom_range(0, 70)));
      m[i] = ($urandom_range(0, 4) != 0);
    end
  endtask

  // One clock cycle: drive at the negedge, check the handshake, update the
  // scoreboard, then advance to the next negedge.
  task automatic cycle(input logic v, input logic [LANES*WIDTH-1:0] d,
                       input logic [LANES*EXP_W-1:0] e, input logic [LANES-1:0] m,
                       input logic r, output logic acc);
    beat_t eb;
    in_valid  = v;
    in_data   = d;
    in_exp    = e;
    in_mask   = m;
    out_ready = r;
    #1;
    if (stall_prev) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      cmp_beat("stall_hold", held);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_beat", 64'd1, 64'd0);
      else begin
        eb = exp_q.pop_front();
        cmp_beat("beat", eb);
        emits++;
      end
    end
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(model(d, e, m));
    stall_prev = out_valid && !out_ready;
    held.data = out_data;
    held.emax = out_emax;
`ifdef ALIGN_STICKY_EN
    held.sticky = out_sticky;
`else
    held.sticky = '0;
`endif
    @(negedge clk);
  endtask

  logic [LANES*WIDTH-1:0] d, bd[8];
  logic [LANES*EXP_W-1:0] e, be[8];
  logic [LANES-1:0]       m, bm[8];
  logic                   acc;
  logic                   saw_block;
  logic signed [WIDTH-1:0] neg5;
  logic [WIDTH-1:0]       ones;
  int                     sent, cyc, e0;

  initial begin
    n_cmp = 0; n_bad = 0; emits = 0; stall_prev = 1'b0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_exp = '0; in_mask = '0;
    held.data = '0; held.emax = '0; held.sticky = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(|out_data), 64'd0);
    chk("rst_out_emax", 64'(out_emax), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef ALIGN_STICKY_EN
    chk("rst_out_sticky", 64'(out_sticky), 64'd0);
`endif

    // Basic alignment and two-cycle latency
    for (int i = 0; i < LANES; i++) begin
      d[i*WIDTH +: WIDTH] = WIDTH'('h100);
      e[i*EXP_W +: EXP_W] = (i == 0) ? EXP_W'(20) : EXP_W'(18);
    end
    m = '1;
    cycle(1'b1, d, e, m, 1'b1, acc);
    chk("lat_cycle1_valid", 64'(out_valid), 64'd0);
    cycle(1'b0, d, e, m, 1'b1, acc);
    chk("lat_cycle2_valid", 64'(out_valid), 64'd1);
    chk("t2_emax", 64'(out_emax), 64'd20);
    chk("t2_lane0", 64'(out_data[0 +: WIDTH]), 64'h100);
    chk("t2_lane1", 64'(out_data[WIDTH +: WIDTH]), 64'h40);
    chk("t2_lane15", 64'(out_data[15*WIDTH +: WIDTH]), 64'h40);
`ifdef ALIGN_STICKY_EN
    chk("t2_sticky", 64'(out_sticky), 64'd0);
`endif
    cycle(1'b0, d, e, m, 1'b1, acc);

    // A shift beyond the lane width leaves only the sign
    rand_beat(d, e, m);
    neg5 = WIDTH'(-5);
    ones = '1;
    m = '1;
    for (int i = 0; i < LANES; i++) e[i*EXP_W +: EXP_W] = EXP_W'($urandom_range(0, 60));
    d[3*WIDTH +: WIDTH] = neg5;
    e[3*EXP_W +: EXP_W] = EXP_W'(2);
    e[7*EXP_W +: EXP_W] = EXP_W'(60);
    cycle(1'b1, d, e, m, 1'b1, acc);
    cycle(1'b0, d, e, m, 1'b1, acc);
    chk("t3_emax", 64'(out_emax), 64'd60);
    chk("t3_lane3", 64'(out_data[3*WIDTH +: WIDTH]), 64'(ones));
`ifdef ALIGN_STICKY_EN
    chk("t3_sticky3", 64'(out_sticky[3]), 64'd1);
`endif
    cycle(1'b0, d, e, m, 1'b1, acc);

    // Eight back-to-back beats with a downstream stall in cycles 3-5
    for (int k = 0; k < 8; k++) rand_beat(bd[k], be[k], bm[k]);
    e0 = emits; sent = 0; cyc = 0; saw_block = 1'b0;
    while (sent < 8 && cyc < 60) begin
      #1;
      out_ready = !(cyc >= 3 && cyc <= 5);
      #1;
      if (!in_ready) saw_block = 1'b1;
      cycle(1'b1, bd[sent], be[sent], bm[sent], !(cyc >= 3 && cyc <= 5), acc);
      if (acc) sent++;
      cyc++;
    end
    chk("t4_all_sent", 64'(sent), 64'd8);
    chk("t4_in_ready_dropped", 64'(saw_block), 64'd1);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      cycle(1'b0, d, e, m, 1'b1, acc);
      cyc++;
    end
    chk("t4_emitted", 64'(emits - e0), 64'd8);

    // All lanes masked still yields exactly one zero beat
    e0 = emits;
    d = '1; e = '1; m = '0;
    cycle(1'b1, d, e, m, 1'b1, acc);
    cycle(1'b0, d, e, m, 1'b1, acc);
    chk("t5_valid", 64'(out_valid), 64'd1);
    chk("t5_emax", 64'(out_emax), 64'd0);
    chk("t5_data", 64'(|out_data), 64'd0);
    repeat (4) cycle(1'b0, d, e, m, 1'b1, acc);
    chk("t5_one_beat", 64'(emits - e0), 64'd1);

    // Reset with two beats in flight drops both
    rand_beat(d, e, m);
    cycle(1'b1, d, e, m, 1'b0, acc);
    rand_beat(d, e, m);
    cycle(1'b1, d, e, m, 1'b0, acc);
    chk("t6_pipe_full", 64'(out_valid), 64'd1);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    stall_prev = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("t6_no_out%0d", k), 64'(out_valid), 64'd0);
      cycle(1'b0, d, e, m, 1'b1, acc);
    end

    // Random traffic with random backpressure
    for (int k = 0; k < 400; k++) begin
      rand_beat(d, e, m);
      cycle($urandom_range(0, 3) != 0, d, e, m, $urandom_range(0, 3) != 0, acc);
    end
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      cycle(1'b0, d, e, m, 1'b1, acc);
      cyc++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
